cle_unlock_sequencer: RTL

// Bus-master sequencer that drives the CLE3C0 protection device's unlock protocol.

---
 rtl/cle_unlock_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/cle_unlock_sequencer.sv
// Drives the CLE3C0 unlock protocol: SEQ_LEN strobed accesses, SDRD capture, signature compare.
// Per step STROBE_CYCLES+2 cycles with gnt held; losing bus_gnt parks the sequencer in REQ between steps.
module cle_unlock_sequencer #(
    parameter int SEQ_LEN       = 8,
    parameter int STROBE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [4*SEQ_LEN-1:0]   key_seq,
    input  logic [SEQ_LEN-1:0]     expect_sig,
    input  logic                   bus_gnt,
    input  logic                   SDRD,
    output logic                   bus_req,
    output logic                   SSER,
    output logic                   BA13,
    output logic                   BA12,
    output logic [3:0]             BA,
    output logic                   BR_W,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [SEQ_LEN-1:0]     resp
);

    localparam int              CW        = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam logic [CW-1:0]   SC_LAST   = CW'(STROBE_CYCLES - 1);
    localparam logic [3:0]      STEP_LAST = 4'(SEQ_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_SETUP,
        S_STROBE,
        S_RECOVER,
        S_DONE
    } state_t;

    state_t               state, state_nxt;
    logic [3:0]           step, step_nxt;
    logic [CW-1:0]        scnt, scnt_nxt;
    logic [SEQ_LEN-1:0]   resp_nxt;
    logic                 pass_nxt;
    logic [3:0]           key_nib;
    logic                 active;

    // Nibble for the step about to be set up, so BA is valid in the first SETUP cycle.
    always_comb begin
        key_nib = '0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (step_nxt == 4'(i)) key_nib = key_seq[4*i +: 4];
        end
    end

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        scnt_nxt  = scnt;
        resp_nxt  = resp;
        pass_nxt  = pass;
        if (abort && state != S_IDLE) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_nxt = S_REQ;
                        resp_nxt  = '0;
                        pass_nxt  = 1'b0;
                        step_nxt  = '0;
                    end
                end
                S_REQ: begin
                    if (bus_gnt) state_nxt = S_SETUP;
                end
                S_SETUP: begin
                    scnt_nxt  = '0;
                    state_nxt = S_STROBE;
                end
                S_STROBE: begin
                    if (scnt == SC_LAST) begin
                        for (int i = 0; i < SEQ_LEN; i++) begin
                            if (step == 4'(i)) resp_nxt[i] = SDRD;
                        end
                        state_nxt = S_RECOVER;
                    end else begin
                        scnt_nxt = scnt + CW'(1);
                    end
                end
                S_RECOVER: begin
                    if (step == STEP_LAST) begin
                        // resp is complete here, so pass is valid alongside the done pulse.
                        pass_nxt  = (resp == expect_sig);
                        state_nxt = S_DONE;
                    end else begin
                        step_nxt  = step + 4'd1;
                        state_nxt = bus_gnt ? S_SETUP : S_REQ;
                    end
                end
                S_DONE: begin
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign active = (state_nxt == S_SETUP) || (state_nxt == S_STROBE) || (state_nxt == S_RECOVER);

    // Outputs are decoded from the next state and registered, so they track the state exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            step    <= '0;
            scnt    <= '0;
            resp    <= '0;
            pass    <= 1'b0;
            bus_req <= 1'b0;
            SSER    <= 1'b1;
            BA13    <= 1'b0;
            BA12    <= 1'b0;
            BA      <= '0;
            BR_W    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            step    <= step_nxt;
            scnt    <= scnt_nxt;
            resp    <= resp_nxt;
            pass    <= pass_nxt;
            bus_req <= (state_nxt == S_REQ) || active;
            SSER    <= (state_nxt != S_STROBE);
            BA13    <= 1'b0;
            BA12    <= active;
            if (state_nxt == S_SETUP) begin
                BA <= key_nib;
            end else if (!active) begin
                BA <= '0;
            end
            BR_W    <= (state_nxt == S_STROBE);
            busy    <= (state_nxt != S_IDLE);
            done    <= (state_nxt == S_DONE);
        end
    end

endmodule
